// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory bus arbiter.
package mem_bus_arbiter_pkg;

   localparam int WORD_ADDR_W      = 30;
   localparam int WORD_W           = 32;
   localparam int ARB_TIMER_WIDTH  = 8;
   localparam int ARB_STREAK_WIDTH = 4;

   localparam logic READ  = 1'b1;
   localparam logic WRITE = 1'b0;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_BUS_D = 2'd1,
      ARB_BUS_I = 2'd2,
      ARB_RESP  = 2'd3
   } arb_state_e;

   // Saturating increment of the data-grant streak.
   function automatic logic [ARB_STREAK_WIDTH-1:0] streak_inc(
      input logic [ARB_STREAK_WIDTH-1:0] streak,
      input logic [ARB_STREAK_WIDTH-1:0] limit
   );
      logic [ARB_STREAK_WIDTH-1:0] res;
      if (streak >= limit) begin
         res = limit;
      end else begin
         res = streak + 4'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Requester handshakes plus memory bus, bundled for the arbiter port.
interface mem_bus_arbiter_if;
   import mem_bus_arbiter_pkg::*;

   logic                   d_as_;
   logic                   d_rw;
   logic [WORD_ADDR_W-1:0] d_addr;
   logic [WORD_W-1:0]      d_wr_data;
   logic                   d_miss_align;
   logic [WORD_W-1:0]      d_rd_data;
   logic                   d_rdy;
   logic                   d_err;

   logic                   i_req;
   logic [WORD_ADDR_W-1:0] i_addr;
   logic [WORD_W-1:0]      i_rd_data;
   logic                   i_rdy;
   logic                   i_err;

   logic                   bus_as_;
   logic                   bus_rw;
   logic [WORD_ADDR_W-1:0] bus_addr;
   logic [WORD_W-1:0]      bus_wr_data;
   logic [WORD_W-1:0]      bus_rd_data;
   logic                   bus_rdy;

   modport master (
      input  d_as_, d_rw, d_addr, d_wr_data, d_miss_align,
      input  i_req, i_addr,
      input  bus_rd_data, bus_rdy,
      output d_rd_data, d_rdy, d_err,
      output i_rd_data, i_rdy, i_err,
      output bus_as_, bus_rw, bus_addr, bus_wr_data
   );

   modport slave (
      output d_as_, d_rw, d_addr, d_wr_data, d_miss_align,
      output i_req, i_addr,
      output bus_rd_data, bus_rdy,
      input  d_rd_data, d_rdy, d_err,
      input  i_rd_data, i_rdy, i_err,
      input  bus_as_, bus_rw, bus_addr, bus_wr_data
   );

endinterface

// File: rtl/mem_arb_timer.sv
// Clearable saturating bus wait counter; expired flags the last allowed strobe cycle.
module mem_arb_timer
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [ARB_TIMER_WIDTH-1:0] CNT_MAX  = ARB_TIMER_WIDTH'(TIMEOUT);
   localparam logic [ARB_TIMER_WIDTH-1:0] CNT_LAST = ARB_TIMER_WIDTH'(TIMEOUT - 1);

   logic [ARB_TIMER_WIDTH-1:0] count_q;
   logic [ARB_TIMER_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = 8'd0;
      end else if (en && (count_q != CNT_MAX)) begin
         count_d = count_q + 8'd1;
      end else begin
         count_d = count_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 8'd0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds completed strobe cycles, so the current one is the TIMEOUT-th.
   assign expired = (count_q >= CNT_LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port word bus between instruction fetch and load/store,
// with wait-state handshake, misalignment rejection and access timeout.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT      = 255,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   mem_bus_arbiter_if.master bus
);

   localparam logic [ARB_STREAK_WIDTH-1:0] STREAK_MAX = ARB_STREAK_WIDTH'(STARVE_LIMIT);

   arb_state_e                  state_q, state_d;
   logic                        bus_as_q, bus_as_d;
   logic                        bus_rw_q, bus_rw_d;
   logic [WORD_ADDR_W-1:0]      bus_addr_q, bus_addr_d;
   logic [WORD_W-1:0]           bus_wr_data_q, bus_wr_data_d;
   logic [WORD_W-1:0]           d_rd_data_q, d_rd_data_d;
   logic                        d_rdy_q, d_rdy_d;
   logic                        d_err_q, d_err_d;
   logic [WORD_W-1:0]           i_rd_data_q, i_rd_data_d;
   logic                        i_rdy_q, i_rdy_d;
   logic                        i_err_q, i_err_d;
   logic [ARB_STREAK_WIDTH-1:0] streak_q, streak_d;
   logic                        timer_clr_s;
   logic                        timer_en_s;
   logic                        expired_s;

   mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (timer_clr_s),
      .en      (timer_en_s),
      .expired (expired_s)
   );

   always_comb begin
      state_d       = state_q;
      bus_as_d      = bus_as_q;
      bus_rw_d      = bus_rw_q;
      bus_addr_d    = bus_addr_q;
      bus_wr_data_d = bus_wr_data_q;
      d_rd_data_d   = d_rd_data_q;
      d_rdy_d       = 1'b0;
      d_err_d       = 1'b0;
      i_rd_data_d   = i_rd_data_q;
      i_rdy_d       = 1'b0;
      i_err_d       = 1'b0;
      streak_d      = streak_q;
      timer_clr_s   = 1'b1;
      timer_en_s    = 1'b0;

      case (state_q)
         ARB_IDLE: begin
            // Misaligned data is answered directly and never reaches the bus.
            if (!bus.d_as_ && bus.d_miss_align) begin
               state_d = ARB_RESP;
               d_rdy_d = 1'b1;
               d_err_d = 1'b1;
            end else if (!bus.d_as_ && (!bus.i_req || (streak_q < STREAK_MAX))) begin
               state_d       = ARB_BUS_D;
               bus_as_d      = 1'b0;
               bus_rw_d      = bus.d_rw;
               bus_addr_d    = bus.d_addr;
               bus_wr_data_d = bus.d_wr_data;
               if (bus.i_req) begin
                  streak_d = streak_inc(streak_q, STREAK_MAX);
               end else begin
                  streak_d = 4'd0;
               end
            end else if (bus.i_req) begin
               state_d    = ARB_BUS_I;
               bus_as_d   = 1'b0;
               bus_rw_d   = READ;
               bus_addr_d = bus.i_addr;
               streak_d   = 4'd0;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_BUS_D: begin
            timer_en_s  = 1'b1;
            timer_clr_s = bus.bus_rdy | expired_s;
            if (bus.bus_rdy) begin
               state_d  = ARB_RESP;
               bus_as_d = 1'b1;
               d_rdy_d  = 1'b1;
               if (bus_rw_q == READ) begin
                  d_rd_data_d = bus.bus_rd_data;
               end else begin
                  d_rd_data_d = d_rd_data_q;
               end
            end else if (expired_s) begin
               state_d     = ARB_RESP;
               bus_as_d    = 1'b1;
               d_rdy_d     = 1'b1;
               d_err_d     = 1'b1;
               d_rd_data_d = 32'd0;
            end else begin
               state_d = ARB_BUS_D;
            end
         end
         ARB_BUS_I: begin
            timer_en_s  = 1'b1;
            timer_clr_s = bus.bus_rdy | expired_s;
            if (bus.bus_rdy) begin
               state_d     = ARB_RESP;
               bus_as_d    = 1'b1;
               i_rdy_d     = 1'b1;
               i_rd_data_d = bus.bus_rd_data;
            end else if (expired_s) begin
               state_d     = ARB_RESP;
               bus_as_d    = 1'b1;
               i_rdy_d     = 1'b1;
               i_err_d     = 1'b1;
               i_rd_data_d = 32'd0;
            end else begin
               state_d = ARB_BUS_I;
            end
         end
         ARB_RESP: begin
            state_d = ARB_IDLE;
         end
         default: begin
            state_d  = ARB_IDLE;
            bus_as_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ARB_IDLE;
         bus_as_q      <= 1'b1;
         bus_rw_q      <= READ;
         bus_addr_q    <= 30'd0;
         bus_wr_data_q <= 32'd0;
         d_rd_data_q   <= 32'd0;
         d_rdy_q       <= 1'b0;
         d_err_q       <= 1'b0;
         i_rd_data_q   <= 32'd0;
         i_rdy_q       <= 1'b0;
         i_err_q       <= 1'b0;
         streak_q      <= 4'd0;
      end else begin
         state_q       <= state_d;
         bus_as_q      <= bus_as_d;
         bus_rw_q      <= bus_rw_d;
         bus_addr_q    <= bus_addr_d;
         bus_wr_data_q <= bus_wr_data_d;
         d_rd_data_q   <= d_rd_data_d;
         d_rdy_q       <= d_rdy_d;
         d_err_q       <= d_err_d;
         i_rd_data_q   <= i_rd_data_d;
         i_rdy_q       <= i_rdy_d;
         i_err_q       <= i_err_d;
         streak_q      <= streak_d;
      end
   end

   assign bus.bus_as_     = bus_as_q;
   assign bus.bus_rw      = bus_rw_q;
   assign bus.bus_addr    = bus_addr_q;
   assign bus.bus_wr_data = bus_wr_data_q;
   assign bus.d_rd_data   = d_rd_data_q;
   assign bus.d_rdy       = d_rdy_q;
   assign bus.d_err       = d_err_q;
   assign bus.i_rd_data   = i_rd_data_q;
   assign bus.i_rdy       = i_rdy_q;
   assign bus.i_err       = i_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter (TIMEOUT=8, STARVE_LIMIT=4).
module tb_mem_bus_arbiter;
   import mem_bus_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   // Memory model knobs: rdy after mem_wait wait states, or never when hung.
   int          mem_wait = 0;
   bit          mem_hang = 1'b0;
   logic [31:0] rd_base = 32'd0;
   int          wait_cnt = 0;

   int          as_low_cnt = 0;
   int          d_rdy_cnt = 0;
   int          addr_glitch = 0;
   logic        prev_as = 1'b1;
   logic [29:0] prev_addr = 30'd0;
   logic [29:0] grants[$];

   mem_bus_arbiter_if ifc ();

   mem_bus_arbiter #(.TIMEOUT(8), .STARVE_LIMIT(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.master)
   );

   always #5 clk = ~clk;

   assign ifc.bus_rdy     = !ifc.bus_as_ && !mem_hang && (wait_cnt == mem_wait);
   assign ifc.bus_rd_data = rd_base ^ {2'b00, ifc.bus_addr};

   always @(posedge clk) begin
      wait_cnt <= ifc.bus_as_ ? 0 : wait_cnt + 1;
   end

   // Bus observers, sampled on the active edge before the DUT updates.
   always @(posedge clk) begin
      if (!ifc.bus_as_) as_low_cnt++;
      if (ifc.d_rdy) d_rdy_cnt++;
      if (prev_as && !ifc.bus_as_) grants.push_back(ifc.bus_addr);
      if (!prev_as && !ifc.bus_as_ && (ifc.bus_addr != prev_addr)) addr_glitch++;
      prev_as   = ifc.bus_as_;
      prev_addr = ifc.bus_addr;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h required %h", tag, got, exp);
      end
   endtask

   task automatic wait_rdy(input bit is_d, input int budget, output int lat);
      int  k;
      bit  hit;
      k   = 0;
      hit = 1'b0;
      lat = -1;
      while (!hit && (k < budget)) begin
         @(negedge clk);
         if (is_d ? ifc.d_rdy : ifc.i_rdy) begin
            hit = 1'b1;
            lat = k;
         end else begin
            k++;
         end
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      int lat2;
      int snap;
      ifc.d_as_        = 1'b1;
      ifc.d_rw         = READ;
      ifc.d_addr       = 30'd0;
      ifc.d_wr_data    = 32'd0;
      ifc.d_miss_align = 1'b0;
      ifc.i_req        = 1'b0;
      ifc.i_addr       = 30'd0;

      repeat (3) next_cycle();
      chk("rst_bus_as", {31'd0, ifc.bus_as_}, 32'd1);
      chk("rst_bus_rw", {31'd0, ifc.bus_rw}, {31'd0, READ});
      chk("rst_bus_addr", {2'b00, ifc.bus_addr}, 32'd0);
      chk("rst_rdy", {30'd0, ifc.d_rdy, ifc.i_rdy}, 32'd0);
      chk("rst_rd_data", ifc.d_rd_data | ifc.i_rd_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero-wait data load.
      next_cycle();
      rd_base    = 32'hDEADBEFF;
      mem_wait   = 0;
      ifc.d_addr = 30'h10;
      ifc.d_as_  = 1'b0;
      snap       = as_low_cnt;
      wait_rdy(1'b1, 20, lat);
      ifc.d_as_ = 1'b1;
      chk("t1_lat", lat, 32'd2);
      chk("t1_rd_data", ifc.d_rd_data, 32'hDEADBEEF);
      chk("t1_err", {31'd0, ifc.d_err}, 32'd0);
      chk("t1_as_low", as_low_cnt - snap, 32'd1);

      // Simultaneous requests, 2 wait states: data first, then fetch.
      next_cycle();
      rd_base    = 32'd0;
      mem_wait   = 2;
      ifc.d_addr = 30'h20;
      ifc.i_addr = 30'h100;
      ifc.d_as_  = 1'b0;
      ifc.i_req  = 1'b1;
      wait_rdy(1'b1, 20, lat);
      ifc.d_as_ = 1'b1;
      chk("t2_d_lat", lat, 32'd4);
      chk("t2_d_rd_data", ifc.d_rd_data, 32'h20);
      chk("t2_i_not_yet", {31'd0, ifc.i_rdy}, 32'd0);
      wait_rdy(1'b0, 20, lat2);
      ifc.i_req = 1'b0;
      chk("t2_i_after_d", lat2 + 1, 32'd5);
      chk("t2_i_rd_data", ifc.i_rd_data, 32'h100);
      chk("t2_i_err", {31'd0, ifc.i_err}, 32'd0);
      chk("t2_addr_glitch", addr_glitch, 32'd0);

      // Starvation: data and fetch both held; 5th grant must be the fetch.
      next_cycle();
      mem_wait = 0;
      grants.delete();
      ifc.d_addr = 30'h40;
      ifc.i_addr = 30'h200;
      ifc.d_as_  = 1'b0;
      ifc.i_req  = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (grants.size() >= 6) break;
      end
      ifc.d_as_ = 1'b1;
      ifc.i_req = 1'b0;
      chk("t3_grant_cnt", grants.size() >= 6, 32'd1);
      if (grants.size() >= 6) begin
         for (int g = 0; g < 6; g++) begin
            chk($sformatf("t3_grant%0d", g), {2'b00, grants[g]}, (g == 4) ? 32'h200 : 32'h40);
         end
      end
      repeat (3) next_cycle();

      // Misaligned store: answered next cycle, bus untouched, rd_data kept.
      ifc.d_rw         = WRITE;
      ifc.d_addr       = 30'h33;
      ifc.d_wr_data    = 32'h12345678;
      ifc.d_miss_align = 1'b1;
      ifc.d_as_        = 1'b0;
      snap             = as_low_cnt;
      wait_rdy(1'b1, 20, lat);
      ifc.d_as_        = 1'b1;
      ifc.d_miss_align = 1'b0;
      chk("t4_lat", lat, 32'd1);
      chk("t4_err", {31'd0, ifc.d_err}, 32'd1);
      chk("t4_rd_data", ifc.d_rd_data, 32'h40);
      chk("t4_as_low", as_low_cnt - snap, 32'd0);

      // Fetch timeout with a hung memory.
      next_cycle();
      mem_hang   = 1'b1;
      ifc.i_addr = 30'h300;
      ifc.i_req  = 1'b1;
      snap       = as_low_cnt;
      wait_rdy(1'b0, 30, lat);
      ifc.i_req = 1'b0;
      chk("t5_lat", lat, 32'd9);
      chk("t5_err", {31'd0, ifc.i_err}, 32'd1);
      chk("t5_rd_data", ifc.i_rd_data, 32'd0);
      chk("t5_as_low", as_low_cnt - snap, 32'd8);
      @(negedge clk);
      chk("t5_back_idle", {30'd0, ifc.i_rdy, ifc.bus_as_}, 32'd1);

      // Reset during a data wait, then a fresh read and a write.
      next_cycle();
      ifc.d_rw   = READ;
      ifc.d_addr = 30'h50;
      ifc.d_as_  = 1'b0;
      repeat (3) @(negedge clk);
      chk("t6_as_pre", {31'd0, ifc.bus_as_}, 32'd0);
      snap  = d_rdy_cnt;
      rst_n = 1'b0;
      #1;
      chk("t6_as_async", {31'd0, ifc.bus_as_}, 32'd1);
      ifc.d_as_ = 1'b1;
      repeat (2) next_cycle();
      chk("t6_no_rdy", d_rdy_cnt - snap, 32'd0);
      chk("t6_rst_rd_data", ifc.d_rd_data, 32'd0);
      chk("t6_rst_bus_addr", {2'b00, ifc.bus_addr}, 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      mem_hang = 1'b0;
      mem_wait = 1;
      next_cycle();
      ifc.d_addr = 30'h60;
      ifc.d_as_  = 1'b0;
      wait_rdy(1'b1, 20, lat);
      ifc.d_as_ = 1'b1;
      chk("t6_lat", lat, 32'd3);
      chk("t6_rd_data", ifc.d_rd_data, 32'h60);
      chk("t6_err", {31'd0, ifc.d_err}, 32'd0);

      next_cycle();
      mem_wait      = 0;
      ifc.d_rw      = WRITE;
      ifc.d_addr    = 30'h70;
      ifc.d_wr_data = 32'hCAFEF00D;
      ifc.d_as_     = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("t7_bus_as", {31'd0, ifc.bus_as_}, 32'd0);
      chk("t7_bus_rw", {31'd0, ifc.bus_rw}, {31'd0, WRITE});
      chk("t7_bus_addr", {2'b00, ifc.bus_addr}, 32'h70);
      chk("t7_wr_data", ifc.bus_wr_data, 32'hCAFEF00D);
      wait_rdy(1'b1, 20, lat);
      ifc.d_as_ = 1'b1;
      chk("t7_lat", lat, 32'd0);
      chk("t7_rd_kept", ifc.d_rd_data, 32'h60);

      repeat (2) next_cycle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

endmodule
